// File: rtl/twiddle_loader_if.sv
// rtl/twiddle_loader_if.sv - twiddle stream and stage-RAM write bus bundle
//
// Purpose: groups the twiddle input stream (in_valid/in_data/in_ready) and the
// shared stage-RAM write port (write_en/write_addr/write_data/full_ram).
// Modports:
//   master : environment side, drives the stream and the RAM full flags
//   slave  : loader side, accepts the stream and drives the RAM write port
interface twiddle_loader_if #(
  parameter int W          = 32,
  parameter int NUM_STAGES = 3,
  parameter int AW         = 3
);
  logic                  in_valid;
  logic [W-1:0]          in_data;
  logic                  in_ready;
  logic [NUM_STAGES-1:0] full_ram;
  logic [NUM_STAGES-1:0] write_en;
  logic [AW-1:0]         write_addr;
  logic [W-1:0]          write_data;

  modport master (
    output in_valid, in_data, full_ram,
    input  in_ready, write_en, write_addr, write_data
  );

  modport slave (
    input  in_valid, in_data, full_ram,
    output in_ready, write_en, write_addr, write_data
  );
endinterface

// File: rtl/twiddle_loader.sv
// rtl/twiddle_loader.sv - distributes a twiddle stream into per-stage twiddle RAMs
//
// Purpose: accepts twiddle words in order, writes them to stage 0 address 0
// upward across NUM_STAGES RAMs, waits for every RAM to report full, then
// raises load_done.
// Optional feature macro: TWIDDLE_RANGE_CHECK_EN (sticky range_err when an
// accepted word is >= MODULUS; otherwise range_err is tied to 0).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_start  : one-cycle pulse, begins or restarts a load
//   bus (slave) : in_valid/in_data/in_ready stream, full_ram flags,
//                 write_en/write_addr/write_data RAM write port
//   load_done   : all stages loaded and full
//   range_err   : sticky out-of-range flag
module twiddle_loader #(
  parameter int W                    = 32,
  parameter int MODULUS              = 7681,
  parameter int NUM_STAGES           = 3,
  parameter int twiddle_buffer_depth = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  twiddle_loader_if.slave   bus,
  output logic              load_done,
  output logic              range_err
);

  localparam int AW = $clog2(twiddle_buffer_depth);
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [AW-1:0] ADDR_LAST  = AW'(twiddle_buffer_depth - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_FULL, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr_cnt;
  logic [SW-1:0] stage_cnt;
  logic          accept;
  logic          last_word;

  // load_start wins over a simultaneous accept: the offered word is dropped.
  assign accept    = (state == LOAD) && bus.in_ready && bus.in_valid && !load_start;
  assign last_word = (stage_cnt == STAGE_LAST) && (addr_cnt == ADDR_LAST);

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE:      state_nxt = IDLE;
        LOAD:      if (accept && last_word) state_nxt = WAIT_FULL;
        WAIT_FULL: if (&bus.full_ram) state_nxt = DONE;
        DONE:      state_nxt = DONE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // in_ready and load_done are registered from the next state so they are
  // clean flops with no path from in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.in_ready <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.in_ready <= (state_nxt == LOAD);
      load_done    <= (state_nxt == DONE);
    end
  end

  // The stage counter only advances when the address wraps; it may run one
  // past the last stage after the final word, which is harmless because the
  // next load_start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt  <= '0;
      stage_cnt <= '0;
    end else if (load_start) begin
      addr_cnt  <= '0;
      stage_cnt <= '0;
    end else if (accept) begin
      addr_cnt <= addr_cnt + 1'b1;
      if (addr_cnt == ADDR_LAST) stage_cnt <= stage_cnt + 1'b1;
    end
  end

  // Address and data hold their last values between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.write_en   <= '0;
      bus.write_addr <= '0;
      bus.write_data <= '0;
    end else begin
      bus.write_en <= '0;
      if (accept) begin
        bus.write_en   <= NUM_STAGES'(1) << stage_cnt;
        bus.write_addr <= addr_cnt;
        bus.write_data <= bus.in_data;
      end
    end
  end

`ifdef TWIDDLE_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else if (load_start) begin
      range_err <= 1'b0;
    end else if (accept && (bus.in_data >= W'(MODULUS))) begin
      range_err <= 1'b1;
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule
